cv32e40p_mult_issue: RTL
========================

Name: cv32e40p_mult_issue

Overview:
- Initiator-side controller for cv32e40p_mult.
- Accepts multiply commands from an upstream requester on a valid/ready port.
- Drives the multiplier operand/control bundle and holds `enable` until the multiplier reports `ready`.
- Captures each result into a response register and returns it with the command's tag and a cycle count.
- Sits between EX-stage issue logic (or an accelerator queue) and the multiplier, and owns the `ex_ready` handshake on the multiplier side.

Parameters:
- TAG_W, 4, width of the opaque command tag passed through to the response.
- CNT_W, 4, width of the saturating per-command cycle counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset. The multiplier's rst_n is driven from ~rst at top level.
- req_valid_i  in  1  command valid.
- req_ready_o  out  1  command accepted when req_valid_i && req_ready_o.
- req_i  in  mult_req_t  operator, short_subword, short_signed, op_a/b/c, imm, dot_signed, dot_op_a/b/c, is_clpx, clpx_shift, clpx_img.
- req_tag_i  in  TAG_W  command tag.
- mult_enable_o  out  1  to multiplier enable_i.
- mult_req_o  out  mult_req_t  to multiplier operand/control inputs. All-zero when mult_enable_o=0.
- mult_ex_ready_o  out  1  to multiplier ex_ready_i.
- mult_result_i  in  32  from multiplier result_o.
- mult_ready_i  in  1  from multiplier ready_o.
- mult_multicycle_i  in  1  from multiplier multicycle_o.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when rsp_valid_o && rsp_ready_i.
- rsp_result_o  out  32  captured result.
- rsp_tag_o  out  TAG_W  tag of the completed command.
- rsp_cycles_o  out  CNT_W  cycles mult_enable_o was high for this command, saturating at 2^CNT_W-1.
- rsp_multi_o  out  1  mult_multicycle_i was seen high during this command.

Behaviour:
- Reset: state IDLE; cmd register empty; rsp_valid_o=0; mult_enable_o=0; mult_ex_ready_o=0; mult_req_o=0; rsp_result_o, rsp_tag_o, rsp_cycles_o, rsp_multi_o all 0. Reset asserted mid-command discards the command and any pending response; no response is produced for it.
- FSM has two states, IDLE and BUSY.
  - IDLE: mult_enable_o=0. On a request handshake, latch req_i/req_tag_i into the cmd register, clear cnt and multi, go to BUSY.
  - BUSY: mult_enable_o=1 and mult_req_o=cmd. cnt increments, saturating, every BUSY cycle; multi |= mult_multicycle_i.
- Completion cycle: BUSY && mult_ready_i && slot_free, where slot_free = !rsp_valid_o || rsp_ready_i.
  - In that cycle mult_ex_ready_o=1.
  - Next edge: rsp register <= {mult_result_i, tag, cnt+1 (saturated), multi|mult_multicycle_i}; rsp_valid_o=1.
- BUSY && mult_ready_i && !slot_free: mult_ex_ready_o=0. Command, enable and operands are held stable; the multiplier holds its result. Completion is retried every cycle.
- mult_ex_ready_o = BUSY && slot_free at all times. It is 0 in IDLE.
- req_ready_o = IDLE || completion cycle. A new command may be latched in the completion cycle; FSM stays BUSY and issues it on the next cycle.
- Latency and throughput:
  - Request accepted at edge N gives enable at cycle N+1.
  - A single-cycle op completes at N+1; rsp_valid_o is high from N+2.
  - Sustained throughput is one command per cycle for single-cycle ops when rsp_ready_i=1.
- MULH-class ops: mult_ready_i stays low while the multiplier iterates. The issuer only waits; it never drops enable mid-command.
- Response register: rsp_valid_o is cleared on a consume with no simultaneous completion. A simultaneous consume and completion reloads the register and keeps rsp_valid_o=1.
- Operands change only when mult_enable_o rises or on a completion-cycle reload. They never change while BUSY and not completing.
- cnt arithmetic: CNT_W bits, saturating. Completion with cnt already at max reports max.

Decomposition:
- cv32e40p_pkg gains mult_req_t, a packed struct of all multiplier control/operand fields using the existing mul_opcode_e, plus the localparam MULT_REQ_W.
- Sub-module cv32e40p_mult_rsp_reg: a one-entry valid/ready response register with load/consume. It is reused elsewhere as a generic skid slot.
- The FSM, cmd register and counter stay in the top module.

Test Plan:
- MUL_I, op_a=5, op_b=10, rsp_ready=1 -> rsp_result=50, rsp_cycles=1, rsp_multi=0, rsp_valid rises two edges after the request handshake.
- Back-to-back MUL_I(-5*10) then MUL_MAC32(5*10+20) then MUL_MSU32(100-5*10), req_valid held -> responses 0xFFFFFFCE, 70, 50 on consecutive cycles with tags in order; req_ready never low.
- MUL_H with short_signed=2'b11, op_a=op_b=0x80000000 -> rsp_result=0x40000000, rsp_multi=1, rsp_cycles equals the observed count of enable-high cycles; operands stable throughout.
- Backpressure: rsp_ready=0 for 3 cycles while a second MUL_I 7*6 is BUSY -> mult_ex_ready=0, req_ready=0, operands held. Once rsp_ready=1, the first response drains and 42 appears next cycle.
- DOT8 with dot_signed=2'b11, a=b=0x7F7F7F7F, c=0x0A -> 64526 (4*127*127+10), cycles=1. An enable-idle cycle shows mult_req_o=0.
- Reset asserted mid MUL_H (BUSY, 2nd cycle) -> next cycle mult_enable_o=0, rsp_valid_o=0, req_ready_o=1. A following MUL_I 3*3 returns 9 with cycles=1.

Source files
------------

// File: rtl/cv32e40p_pkg.sv
// Shared multiplier types: opcode encoding, operand/control bundle and
// the issue controller state encoding.
package cv32e40p_pkg;

    typedef enum logic [2:0] {
        MUL_MAC32 = 3'b000,
        MUL_MSU32 = 3'b001,
        MUL_I     = 3'b010,
        MUL_IR    = 3'b011,
        MUL_DOT8  = 3'b100,
        MUL_DOT16 = 3'b101,
        MUL_H     = 3'b110
    } mul_opcode_e;

    typedef struct packed {
        mul_opcode_e operator;
        logic        short_subword;
        logic [1:0]  short_signed;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] op_c;
        logic [4:0]  imm;
        logic [1:0]  dot_signed;
        logic [31:0] dot_op_a;
        logic [31:0] dot_op_b;
        logic [31:0] dot_op_c;
        logic        is_clpx;
        logic [1:0]  clpx_shift;
        logic        clpx_img;
    } mult_req_t;

    localparam int MULT_REQ_W = $bits(mult_req_t);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mult_issue_state_e;

endpackage

// File: rtl/cv32e40p_mult_rsp_reg.sv
// One-entry valid/ready holding register. The owner must only assert load
// while free is high; a load in the same cycle as a consume replaces the entry.
module cv32e40p_mult_rsp_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         free
);

    assign free = !valid || ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cv32e40p_mult_issue.sv
// Issues multiply commands to cv32e40p_mult, holds enable until the result is
// taken, and returns result, tag, enable-cycle count and multicycle flag.
module cv32e40p_mult_issue
    import cv32e40p_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  mult_req_t        req_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             mult_enable_o,
    output mult_req_t        mult_req_o,
    output logic             mult_ex_ready_o,
    input  logic [31:0]      mult_result_i,
    input  logic             mult_ready_i,
    input  logic             mult_multicycle_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_result_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic [CNT_W-1:0] rsp_cycles_o,
    output logic             rsp_multi_o
);

    localparam int RSP_W = 32 + TAG_W + CNT_W + 1;

    mult_issue_state_e state;
    mult_req_t         cmd;
    logic [TAG_W-1:0]  tag;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              multi;
    logic              busy;
    logic              slot_free;
    logic              complete;
    logic              accept;
    logic [RSP_W-1:0]  rsp_data;

    assign busy     = (state == BUSY);
    assign complete = busy && mult_ready_i && slot_free;
    assign accept   = req_valid_i && req_ready_o;
    assign cnt_inc  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

    // The multiplier only advances past a result when ex_ready is high, so
    // tying it to slot_free makes the multiplier hold its result for us.
    assign req_ready_o     = !busy || complete;
    assign mult_enable_o   = busy;
    assign mult_ex_ready_o = busy && slot_free;
    assign mult_req_o      = busy ? cmd : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cmd   <= '0;
            tag   <= '0;
            cnt   <= '0;
            multi <= 1'b0;
        end else if (accept) begin
            state <= BUSY;
            cmd   <= req_i;
            tag   <= req_tag_i;
            cnt   <= '0;
            multi <= 1'b0;
        end else if (complete) begin
            state <= IDLE;
        end else if (busy) begin
            cnt   <= cnt_inc;
            multi <= multi | mult_multicycle_i;
        end
    end

    // The completion cycle itself counts, hence cnt_inc and the live multicycle bit.
    cv32e40p_mult_rsp_reg #(.W(RSP_W)) u_rsp (
        .clk       (clk),
        .rst       (rst),
        .load      (complete),
        .load_data ({mult_result_i, tag, cnt_inc, multi | mult_multicycle_i}),
        .ready     (rsp_ready_i),
        .valid     (rsp_valid_o),
        .data      (rsp_data),
        .free      (slot_free)
    );

    assign {rsp_result_o, rsp_tag_o, rsp_cycles_o, rsp_multi_o} = rsp_data;

endmodule
